text_render_ctrl: RTL and testbench
===================================

Name: text_render_ctrl

Overview:
- Sequences the on-screen string ROM (index -> ASCII code) and the 8x8 font ROM to produce one text pixel per clock for the VGA pixel pipeline.
- Maps the current pixel position to a character slot and drives the string ROM index from that slot.
- Forms the font ROM address from the returned ASCII code and the glyph row, then selects the glyph bit.
- Adds a typewriter reveal: characters appear one at a time, paced by frame ticks.

Parameters:
- X0, 10'd0: left pixel column of the text box.
- Y0, 10'd0: top pixel row of the text box.
- NCHARS, 5: string length in characters (1..16).
- REVEAL_FRAMES, 8: frame ticks per additional revealed character (>=1).

Ports:
- clk  in  1  pixel clock
- rstn  in  1  asynchronous active-low reset
- px_x  in  10  current pixel column
- px_y  in  10  current pixel row
- px_valid  in  1  pixel inside visible area
- frame_tick  in  1  one-cycle pulse per frame
- restart  in  1  synchronous: hide all characters, restart reveal
- idx  out  4  string ROM index
- ascii_code  in  8  string ROM data (combinational from idx)
- font_addr  out  11  {ascii[7:0], glyph_row[2:0]} to font ROM
- font_data  in  8  font ROM row (synchronous ROM, 1-cycle read latency, bit7 = leftmost pixel)
- pix_on  out  1  text pixel lit
- pix_valid  out  1  px_valid delayed to align with pix_on
- shown  out  5  characters currently revealed (0..NCHARS)

Behaviour:
- Reset values (async, rstn=0): idx=0, font_addr=0, pix_on=0, pix_valid=0, shown=0, frame counter=0, all pipeline registers=0.
- Offsets: dx = px_x-X0 and dy = px_y-Y0, computed at 10 bits.
- In-box test: px_x>=X0 && px_x<X0+8*NCHARS && px_y>=Y0 && px_y<Y0+8.
- Slot fields: col=dx[6:3], bit=dx[2:0], row=dy[2:0].
- Hit: px_valid && in-box && col<shown.
- Pipeline, inputs sampled at edge E0:
  - S1 @E0: register idx=col (idx=0 when not in-box), plus hit, bit, row, px_valid.
  - S2 @E1: font_addr={ascii_code,row}. Propagate hit (cleared if ascii_code==8'h00), bit, px_valid.
  - S3 @E2: font ROM registers font_data. Controller delays hit, bit, px_valid one stage.
  - S4 @E3: pix_on=hit && font_data[7-bit]; pix_valid=px_valid.
- Total latency is 4 edges: pix_on for the pixel presented before E0 is visible after E3. Fully pipelined; a new pixel is accepted every cycle with no stalls.
- idx and font_addr hold their last value when not hit; the ROMs are read harmlessly.
- Reveal sequencer:
  - States: REVEALING, DONE.
  - REVEALING: each frame_tick increments the frame counter. When the counter reaches REVEAL_FRAMES-1 on a tick, it clears to 0 and shown increments.
  - Entering DONE: when shown reaches NCHARS, go to DONE. shown saturates at NCHARS and ticks are ignored.
  - restart=1: shown=0, counter=0, state=REVEALING on the next edge from any state.
  - restart and frame_tick in the same cycle: restart wins, no increment.
- shown changes only at frame_tick or restart, so mid-frame pixels see a stable value except at restart. A restart mid-line takes effect for pixels sampled on or after the following edge.
- Reset mid-operation clears the pipeline. Garbage is never output; pix_on=0 for the first 4 cycles after reset release.
- Width rules: X0+8*NCHARS must be <=1023; this is checked by an elaboration-time assertion.

Test Plan:
- Reset: hold rstn=0 with random inputs -> pix_on=0, pix_valid=0, shown=0, idx=0. Release -> pix_on stays 0 for 4 cycles.
- Latency/decode: X0=16, Y0=8, shown forced to NCHARS via 40 ticks, string "Alex!".
  - Present px_x=16..55, px_y=8 (row 0) -> idx sequence 0..4 per 8 pixels; font_addr[10:3] = 41,6c,65,78,21.
  - pix_on equals the font row 0 bits MSB-first, delayed 4 cycles; pix_valid tracks px_valid delayed 4 cycles.
- Box boundaries:
  - px_x=15 or 56, or px_y=7 or 16 -> pix_on=0.
  - px_x=55, px_y=15 -> pix_on = font_data[0] of '!' row 7.
  - px_valid=0 inside the box -> pix_on=0.
- Reveal pacing with REVEAL_FRAMES=8:
  - 7 ticks -> shown=0; 8th tick -> shown=1; 40 ticks -> shown=5; 41+ ticks -> shown stays 5.
  - With shown=2, pixels in slots 2..4 give pix_on=0.
- Restart: restart and frame_tick asserted together with shown=3 -> next cycle shown=0, counter=0. A further 8 ticks -> shown=1.
- Async reset mid-frame: assert rstn=0 between edges during a lit pixel stream -> outputs drop to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/text_render_ctrl.sv
// Text overlay renderer: maps the pixel position to a string slot, fetches glyph rows
// from the font ROM and emits one text pixel per clock, with a frame-paced typewriter reveal.
module text_render_ctrl #(
    parameter logic [9:0] X0            = 10'd0,
    parameter logic [9:0] Y0            = 10'd0,
    parameter int         NCHARS        = 5,
    parameter int         REVEAL_FRAMES = 8
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [9:0]  px_x,
    input  logic [9:0]  px_y,
    input  logic        px_valid,
    input  logic        frame_tick,
    input  logic        restart,
    output logic [3:0]  idx,
    input  logic [7:0]  ascii_code,
    output logic [10:0] font_addr,
    input  logic [7:0]  font_data,
    output logic        pix_on,
    output logic        pix_valid,
    output logic [4:0]  shown
);

    localparam int         CW    = (REVEAL_FRAMES > 1) ? $clog2(REVEAL_FRAMES) : 1;
    localparam logic [9:0] BOX_W = 10'(8 * NCHARS);

    generate
        if ((int'(X0) + 8 * NCHARS > 1023) || (NCHARS < 1) || (NCHARS > 16) || (REVEAL_FRAMES < 1)) begin : g_param_check
            $error("text_render_ctrl: illegal parameter combination");
        end
    endgenerate

    typedef enum logic {REVEALING, DONE} state_t;

    state_t          state, state_next;
    logic [CW-1:0]   frame_cnt, cnt_next;
    logic [4:0]      shown_next;

    logic [10:0] diff_x, diff_y;
    logic        in_box, hit;
    logic [3:0]  col;
    logic [2:0]  bit_sel, row;

    logic        s1_hit, s1_valid;
    logic [2:0]  s1_bit, s1_row;
    logic        s2_hit, s2_valid;
    logic [2:0]  s2_bit;
    logic        s3_hit, s3_valid;
    logic [2:0]  s3_bit;

    // A borrow out of the 11-bit subtraction means the pixel lies left of / above the box.
    assign diff_x  = {1'b0, px_x} - {1'b0, X0};
    assign diff_y  = {1'b0, px_y} - {1'b0, Y0};
    assign in_box  = !diff_x[10] && (diff_x[9:0] < BOX_W) && !diff_y[10] && (diff_y[9:0] < 10'd8);
    assign col     = diff_x[6:3];
    assign bit_sel = diff_x[2:0];
    assign row     = diff_y[2:0];
    assign hit     = px_valid && in_box && ({1'b0, col} < shown);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idx       <= 4'd0;
            s1_hit    <= 1'b0;
            s1_valid  <= 1'b0;
            s1_bit    <= 3'd0;
            s1_row    <= 3'd0;
            font_addr <= 11'd0;
            s2_hit    <= 1'b0;
            s2_valid  <= 1'b0;
            s2_bit    <= 3'd0;
            s3_hit    <= 1'b0;
            s3_valid  <= 1'b0;
            s3_bit    <= 3'd0;
            pix_on    <= 1'b0;
            pix_valid <= 1'b0;
        end else begin
            idx      <= in_box ? col : 4'd0;
            s1_hit   <= hit;
            s1_valid <= px_valid;
            s1_bit   <= bit_sel;
            s1_row   <= row;

            if (s1_hit) begin
                font_addr <= {ascii_code, s1_row};
            end
            s2_hit   <= s1_hit && (ascii_code != 8'h00);
            s2_valid <= s1_valid;
            s2_bit   <= s1_bit;

            s3_hit   <= s2_hit;
            s3_valid <= s2_valid;
            s3_bit   <= s2_bit;

            // Bit 7 is the leftmost pixel, so column offset b selects bit 7-b (= ~b).
            pix_on    <= s3_hit && font_data[~s3_bit];
            pix_valid <= s3_valid;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= REVEALING;
            frame_cnt <= '0;
            shown     <= 5'd0;
        end else begin
            state     <= state_next;
            frame_cnt <= cnt_next;
            shown     <= shown_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = frame_cnt;
        shown_next = shown;
        if (restart) begin
            state_next = REVEALING;
            cnt_next   = '0;
            shown_next = 5'd0;
        end else if (state == REVEALING && frame_tick) begin
            if (frame_cnt == CW'(REVEAL_FRAMES - 1)) begin
                cnt_next   = '0;
                shown_next = shown + 5'd1;
                if (shown + 5'd1 == 5'(NCHARS)) begin
                    state_next = DONE;
                end
            end else begin
                cnt_next = frame_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_text_render_ctrl.sv
// Directed bench for text_render_ctrl: box at (16,8), string "Alex!", models both ROMs
// and compares pipelined pixel output, ROM addressing and reveal pacing.
module tb_text_render_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic [9:0]  px_x, px_y;
    logic        px_valid, frame_tick, restart;
    logic [3:0]  idx;
    logic [7:0]  ascii_code;
    logic [10:0] font_addr;
    logic [7:0]  font_data;
    logic        pix_on, pix_valid;
    logic [4:0]  shown;

    int checks = 0;
    int errors = 0;

    int          model_shown = 0;
    int          model_cnt = 0;
    logic        exp_q[$];
    logic        expv_q[$];
    logic        prev_hit = 1'b0;
    logic [10:0] prev_addr = 11'd0;

    always #5 clk = ~clk;

    text_render_ctrl #(
        .X0(10'd16), .Y0(10'd8), .NCHARS(5), .REVEAL_FRAMES(8)
    ) dut (
        .clk(clk), .rstn(rstn), .px_x(px_x), .px_y(px_y), .px_valid(px_valid),
        .frame_tick(frame_tick), .restart(restart), .idx(idx), .ascii_code(ascii_code),
        .font_addr(font_addr), .font_data(font_data), .pix_on(pix_on),
        .pix_valid(pix_valid), .shown(shown)
    );

    function automatic logic [7:0] str_rom(input logic [3:0] i);
        case (i)
            4'd0:    return 8'h41;
            4'd1:    return 8'h6c;
            4'd2:    return 8'h65;
            4'd3:    return 8'h78;
            4'd4:    return 8'h21;
            default: return 8'h00;
        endcase
    endfunction

    // Synthetic glyph table: any fixed byte pattern with mixed lit/dark bits will do.
    function automatic logic [7:0] glyph(input logic [7:0] a, input logic [2:0] r);
        return 8'(a * 8'd29) ^ {r, r, r[1:0]} ^ 8'hA5;
    endfunction

    assign ascii_code = str_rom(idx);
    always @(posedge clk) font_data <= glyph(font_addr[10:3], font_addr[2:0]);

    task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic popCompare();
        logic e, ev;
        e  = exp_q.pop_front();
        ev = expv_q.pop_front();
        checkOutput("pix_on", 16'(pix_on), 16'(e));
        checkOutput("pix_valid", 16'(pix_valid), 16'(ev));
    endtask

    // Present one pixel, then check idx, font_addr and the pixel issued four edges earlier.
    task automatic applyStimulus(input int x, input int y, input logic v);
        logic       hit, e;
        logic [3:0] c;
        logic [2:0] b, r;
        logic [7:0] a, g;
        hit = 1'b0; e = 1'b0; c = 4'd0; b = 3'd0; r = 3'd0; a = 8'd0;
        px_x = 10'(x); px_y = 10'(y); px_valid = v;
        if (x >= 16 && x < 56 && y >= 8 && y < 16) begin
            c   = 4'((x - 16) / 8);
            b   = 3'((x - 16) % 8);
            r   = 3'(y - 8);
            a   = str_rom(c);
            g   = glyph(a, r);
            hit = v && (int'(c) < model_shown);
            e   = hit && (a != 8'h00) && g[7 - int'(b)];
        end
        exp_q.push_back(e);
        expv_q.push_back(v);
        @(posedge clk); #1;
        if (hit) checkOutput("idx", 16'(idx), 16'(c));
        if (prev_hit) checkOutput("font_addr", 16'(font_addr), 16'(prev_addr));
        prev_hit  = hit;
        prev_addr = {a, r};
        if (exp_q.size() == 4) popCompare();
    endtask

    task automatic flushPipe();
        px_valid = 1'b0; px_x = 10'd0; px_y = 10'd0;
        prev_hit = 1'b0;
        while (exp_q.size() > 0) begin
            @(posedge clk); #1;
            popCompare();
        end
    endtask

    task automatic applyTicks(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            @(posedge clk); #1;
            if (model_shown < 5) begin
                if (model_cnt == 7) begin
                    model_cnt = 0;
                    model_shown++;
                end else begin
                    model_cnt++;
                end
            end
        end
        frame_tick = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; restart = 1'b0; frame_tick = 1'b0;
        px_x = 10'd0; px_y = 10'd0; px_valid = 1'b0;

        for (int i = 0; i < 3; i++) begin
            px_x = 10'($urandom_range(0, 1023)); px_y = 10'($urandom_range(0, 1023));
            px_valid = 1'($urandom); frame_tick = 1'($urandom); restart = 1'($urandom);
            @(posedge clk); #1;
            checkOutput("rst_pix_on", 16'(pix_on), 16'd0);
            checkOutput("rst_pix_valid", 16'(pix_valid), 16'd0);
            checkOutput("rst_shown", 16'(shown), 16'd0);
            checkOutput("rst_idx", 16'(idx), 16'd0);
        end
        frame_tick = 1'b0; restart = 1'b0;
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            px_x = 10'(16 + i); px_y = 10'd8; px_valid = 1'b1;
            @(posedge clk); #1;
            checkOutput("post_rst_pix_on", 16'(pix_on), 16'd0);
        end
        px_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        applyTicks(7);
        checkOutput("shown_7", 16'(shown), 16'd0);
        applyTicks(1);
        checkOutput("shown_8", 16'(shown), 16'd1);
        applyTicks(8);
        checkOutput("shown_16", 16'(shown), 16'd2);

        for (int x = 14; x <= 58; x++) applyStimulus(x, 11, (x % 7) != 0);
        flushPipe();

        applyTicks(24);
        checkOutput("shown_40", 16'(shown), 16'd5);
        applyTicks(3);
        checkOutput("shown_sat", 16'(shown), 16'd5);

        for (int x = 16; x <= 55; x++) applyStimulus(x, 8, 1'b1);
        applyStimulus(15, 8, 1'b1);
        applyStimulus(56, 8, 1'b1);
        applyStimulus(30, 7, 1'b1);
        applyStimulus(30, 16, 1'b1);
        applyStimulus(55, 15, 1'b1);
        applyStimulus(20, 10, 1'b0);
        flushPipe();

        restart = 1'b1;
        @(posedge clk); #1;
        restart = 1'b0; model_shown = 0; model_cnt = 0;
        checkOutput("shown_restart", 16'(shown), 16'd0);
        applyTicks(27);
        checkOutput("shown_27", 16'(shown), 16'd3);
        restart = 1'b1; frame_tick = 1'b1;
        @(posedge clk); #1;
        restart = 1'b0; frame_tick = 1'b0; model_shown = 0; model_cnt = 0;
        checkOutput("shown_restart_tick", 16'(shown), 16'd0);
        applyTicks(7);
        checkOutput("shown_after_7", 16'(shown), 16'd0);
        applyTicks(1);
        checkOutput("shown_after_8", 16'(shown), 16'd1);

        applyTicks(32);
        checkOutput("shown_full", 16'(shown), 16'd5);
        for (int x = 16; x < 20; x++) applyStimulus(x, 8, 1'b1);
        checkOutput("pix_on_lit", 16'(pix_on), 16'd1);
        #2;
        rstn = 1'b0;
        #1;
        checkOutput("async_pix_on", 16'(pix_on), 16'd0);
        checkOutput("async_pix_valid", 16'(pix_valid), 16'd0);
        checkOutput("async_shown", 16'(shown), 16'd0);
        checkOutput("async_idx", 16'(idx), 16'd0);
        exp_q.delete(); expv_q.delete();
        prev_hit = 1'b0; model_shown = 0; model_cnt = 0;
        px_valid = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
